// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned TMO_W    = 16;
    localparam int unsigned SETTLE_W = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLock   = 2'd1,
        StWrite  = 2'd2,
        StSettle = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request scanning
// upward from (last + 1) mod N with wrap-around.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    int unsigned pos;

    // Walk from the farthest candidate to the nearest so the nearest match wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = N; k >= 1; k--) begin
            pos = (int'(last) + k) % N;
            if (req[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the COREUART transmit path between byte-stream
// requesters. A grant is held for a whole packet (through the byte tagged
// last), and each byte is written with a one-cycle active-low CSN/WEN strobe.
// Optional stall timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      uart_csn,
    output logic                      uart_wen,
    output logic [BYTE_W-1:0]         uart_data_in,
    input  logic                      uart_txrdy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      abort
);

    // Elaboration-time parameter sanity.
    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || SETTLE_CYC < 1 ||
        SETTLE_CYC > 7 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                busy_q, busy_d;
    logic                strobe_q, strobe_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                is_last_q, is_last_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                accept;
    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TmoLimit = TMO_W'(TIMEOUT_CYC - 1);

    logic             abort_q, abort_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req   (req_valid),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign accept = uart_txrdy && req_valid[grant_q];

    // Next-state logic and the combinational byte handshake.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        data_d    = data_q;
        is_last_d = is_last_q;
        settle_d  = settle_q;
        req_ready = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        abort_d   = 1'b0;
        tmo_d     = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Grant only; the first byte is taken in LOCK.
                if (pick_found) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = StLock;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            StLock: begin
                if (accept) begin
                    req_ready[grant_q] = 1'b1;
                    data_d    = req_data[BYTE_W*grant_q +: BYTE_W];
                    is_last_d = req_last[grant_q];
                    strobe_d  = 1'b1;
                    state_d   = StWrite;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmo_d     = '0;
                end else if (req_valid[grant_q]) begin
                    // Owner is still presenting data, only TXRDY is holding us.
                    tmo_d = '0;
                end else if (tmo_q == TmoLimit) begin
                    abort_d = 1'b1;
                    busy_d  = 1'b0;
                    last_d  = grant_q;
                    state_d = StIdle;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            StWrite: begin
                settle_d = SETTLE_W'(SETTLE_CYC);
                state_d  = StSettle;
            end
            StSettle: begin
                // TXRDY is not trusted here; the core's deassert lags the strobe.
                settle_d = settle_q - 1'b1;
                if (settle_q == SETTLE_W'(1)) begin
                    if (is_last_q) begin
                        last_d  = grant_q;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StLock;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A byte taken during reset would be lost, so never handshake then.
        if (RESET) begin
            req_ready = '0;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            data_q    <= '0;
            is_last_q <= 1'b0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            data_q    <= data_d;
            is_last_q <= is_last_d;
            settle_q  <= settle_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Stall counter and abort pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            abort_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            abort_q <= abort_d;
            tmo_q   <= tmo_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign uart_csn     = ~strobe_q;
    assign uart_wen     = ~strobe_q;
    assign uart_data_in = data_q;
    assign grant_id     = grant_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle-time model of the packet
// arbitration rules is checked against the DUT every cycle, plus directed
// literal expectations per scenario.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned ID_W        = 2;
    localparam int unsigned SETTLE_CYC  = 2;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int          BIG         = 1 << 30;

    logic                   CLK;
    logic                   RESET;
    logic [NUM_REQ-1:0]     req_valid;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   uart_csn;
    logic                   uart_wen;
    logic [7:0]             uart_data_in;
    logic                   uart_txrdy;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;
    logic                   abort;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ID_W        (ID_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_csn     (uart_csn),
        .uart_wen     (uart_wen),
        .uart_data_in (uart_data_in),
        .uart_txrdy   (uart_txrdy),
        .grant_id     (grant_id),
        .busy         (busy),
        .abort        (abort)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk;
    int n_fail;

    // Requester byte sources: {last, data} per entry.
    logic [8:0] fifo [NUM_REQ][16];
    int         head [NUM_REQ];
    int         tail [NUM_REQ];

    // Model: time-based view of ownership and scheduled events.
    int                 cyc;
    int                 owner;
    int                 m_last;
    int                 accept_from;
    int                 release_at;
    int                 strobe_at;
    int                 tmo_cnt;
    bit                 live;
    logic               e_busy, n_busy, e_abort, n_abort;
    logic [ID_W-1:0]    e_grant, n_grant;
    logic [7:0]         e_data, n_data;
    logic [NUM_REQ-1:0] exp_ready;

    // Snapshot of DUT outputs at the last sample point.
    logic [NUM_REQ-1:0] s_ready;
    logic               s_csn, s_wen, s_busy, s_abort;
    logic [7:0]         s_data;
    logic [ID_W-1:0]    s_grant;

    int         log_n;
    int         log_id   [64];
    logic [7:0] log_data [64];
    bit         any_abort;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (m_last + k) % NUM_REQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        live        = 1'b1;
        owner       = -1;
        m_last      = NUM_REQ - 1;
        accept_from = BIG;
        release_at  = BIG;
        strobe_at   = -1;
        tmo_cnt     = 0;
        n_busy      = 1'b0;
        n_abort     = 1'b0;
        n_grant     = '0;
        n_data      = '0;
    endtask

    task automatic model_step();
        cyc++;
        e_busy  = n_busy;
        e_grant = n_grant;
        e_data  = n_data;
        e_abort = n_abort;
        if (owner >= 0 && cyc == release_at) begin
            m_last = owner;
            owner  = -1;
        end
        exp_ready = '0;
        if (owner >= 0 && cyc >= accept_from && !RESET && uart_txrdy && req_valid[owner])
            exp_ready[owner] = 1'b1;

        s_ready = req_ready;
        s_csn   = uart_csn;
        s_wen   = uart_wen;
        s_busy  = busy;
        s_abort = abort;
        s_data  = uart_data_in;
        s_grant = grant_id;
        if (s_csn === 1'b0 && log_n < 64) begin
            log_id[log_n]   = int'(s_grant);
            log_data[log_n] = s_data;
            log_n++;
        end
        if (s_abort === 1'b1) any_abort = 1'b1;

        if (live) begin
            chk("m_req_ready", s_ready, exp_ready);
            chk("m_csn", s_csn, (cyc == strobe_at) ? 0 : 1);
            chk("m_wen", s_wen, (cyc == strobe_at) ? 0 : 1);
            chk("m_data", s_data, e_data);
            chk("m_busy", s_busy, e_busy);
            chk("m_grant", s_grant, e_grant);
            chk("m_abort", s_abort, e_abort);
        end

        n_abort = 1'b0;
        if (RESET) begin
            model_reset();
        end else if (live) begin
            if (owner < 0) begin
                if (|req_valid) begin
                    owner       = pick();
                    n_grant     = ID_W'(owner);
                    n_busy      = 1'b1;
                    accept_from = cyc + 1;
                    release_at  = BIG;
                    tmo_cnt     = 0;
                end
            end else if (cyc >= accept_from) begin
                if (exp_ready[owner]) begin
                    strobe_at   = cyc + 1;
                    n_data      = req_data[owner*8 +: 8];
                    accept_from = cyc + SETTLE_CYC + 2;
                    tmo_cnt     = 0;
                    if (req_last[owner]) begin
                        release_at  = cyc + SETTLE_CYC + 2;
                        accept_from = BIG;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                end else if (!req_valid[owner]) begin
                    tmo_cnt++;
                    if (tmo_cnt == TIMEOUT_CYC) begin
                        n_abort     = 1'b1;
                        release_at  = cyc + 1;
                        accept_from = BIG;
                    end
                end else begin
                    tmo_cnt = 0;
`endif
                end
            end
            if (owner >= 0 && cyc + 1 == release_at) n_busy = 1'b0;
        end

        for (int i = 0; i < NUM_REQ; i++)
            if (s_ready[i] === 1'b1 && head[i] < tail[i]) head[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = fifo[i][head[i]][7:0];
                req_last[i]         = fifo[i][head[i]][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit l);
        fifo[i][tail[i]] = {l, d};
        tail[i]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    // Sample and check on the falling edge, drive just after the rising edge.
    task automatic tick();
        @(negedge CLK);
        model_step();
        @(posedge CLK);
        #1;
        drive();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        clear_q();
        drive();
        tick();
        RESET = 1'b0;
        log_n = 0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; live = 1'b0; log_n = 0; any_abort = 1'b0;
        owner = -1; strobe_at = -1; accept_from = BIG; release_at = BIG;
        RESET = 1'b1;
        uart_txrdy = 1'b1;
        clear_q();
        drive();
        repeat (3) tick();

        // Reset values.
        chk("rst_csn", s_csn, 1);
        chk("rst_wen", s_wen, 1);
        chk("rst_data", s_data, 8'h00);
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_grant", s_grant, 0);
        chk("rst_abort", s_abort, 0);

        // Single-byte packet from requester 0.
        RESET = 1'b0;
        log_n = 0;
        push(0, 8'hA5, 1'b1);
        drive();
        tick();
        chk("t1_ready_c1", s_ready, 4'b0000);
        tick();
        chk("t1_ready_c2", s_ready, 4'b0001);
        chk("t1_busy_c2", s_busy, 1);
        tick();
        chk("t1_csn_c3", s_csn, 0);
        chk("t1_wen_c3", s_wen, 0);
        chk("t1_data_c3", s_data, 8'hA5);
        tick();
        tick();
        chk("t1_busy_settle", s_busy, 1);
        tick();
        chk("t1_busy_fall", s_busy, 0);
        chk("t1_grant", s_grant, 0);
        chk("t1_one_strobe", log_n, 1);

        // All four requesters with 3-byte packets, plus a second packet on 0.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            for (int b = 0; b < 3; b++) push(i, {4'(i), 4'(b)}, b == 2);
        for (int b = 0; b < 3; b++) push(0, {4'hA, 4'(b)}, b == 2);
        drive();
        for (int k = 0; k < 300 && log_n < 15; k++) tick();
        chk("t2_strobe_count", log_n >= 15, 1);
        for (int k = 0; k < 15; k++) begin
            chk("t2_order", log_id[k], (k / 3) % 4);
            chk("t2_data", log_data[k], (k < 12) ? {4'(k / 3), 4'(k % 3)} : {4'hA, 4'(k % 3)});
        end

        // TXRDY held low while locked.
        do_reset();
        uart_txrdy = 1'b0;
        push(3, 8'h3C, 1'b1);
        drive();
        repeat (50) tick();
        chk("t3_no_strobe", log_n, 0);
        chk("t3_busy", s_busy, 1);
        chk("t3_grant", s_grant, 3);
        uart_txrdy = 1'b1;
        tick();
        chk("t3_ready_rise", s_ready, 4'b1000);
        tick();
        chk("t3_csn", s_csn, 0);
        chk("t3_data", s_data, 8'h3C);
        repeat (4) tick();

        // Reset landing in the WRITE cycle.
        do_reset();
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        drive();
        for (int k = 0; k < 20 && s_ready[1] !== 1'b1; k++) tick();
        chk("t4_accepted", s_ready[1], 1);
        RESET = 1'b1;
        tick();
        chk("t4_in_write", s_csn, 0);
        RESET = 1'b0;
        clear_q();
        drive();
        tick();
        chk("t4_csn", s_csn, 1);
        chk("t4_wen", s_wen, 1);
        chk("t4_busy", s_busy, 0);
        chk("t4_grant", s_grant, 0);
        log_n = 0;
        push(2, 8'h77, 1'b1);
        drive();
        for (int k = 0; k < 20 && log_n < 1; k++) tick();
        chk("t4_served_id", log_id[0], 2);
        chk("t4_served_data", log_data[0], 8'h77);
        repeat (6) tick();
        chk("t4_one_strobe", log_n, 1);

        // Owner stalls mid-packet while requester 2 waits.
        do_reset();
        any_abort = 1'b0;
        push(1, 8'h51, 1'b0);
        push(2, 8'h62, 1'b1);
        drive();
        for (int k = 0; k < 20 && s_ready[1] !== 1'b1; k++) tick();
        chk("t5_first_byte", s_ready[1], 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
        begin
            int lat;
            lat = 0;
            for (int k = 1; k <= 60 && lat == 0; k++) begin
                tick();
                if (s_abort === 1'b1) lat = k;
            end
            chk("t5_abort_latency", lat, SETTLE_CYC + 2 + TIMEOUT_CYC);
            tick();
            chk("t5_abort_pulse", s_abort, 0);
        end
        for (int k = 0; k < 20 && log_n < 2; k++) tick();
        chk("t5_next_id", log_id[1], 2);
        chk("t5_next_data", log_data[1], 8'h62);
`else
        repeat (40) tick();
        chk("t5_no_abort", any_abort, 0);
        chk("t5_held_busy", s_busy, 1);
        chk("t5_held_grant", s_grant, 1);
        chk("t5_held_strobes", log_n, 1);
        push(1, 8'h52, 1'b0);
        push(1, 8'h53, 1'b1);
        drive();
        for (int k = 0; k < 40 && log_n < 4; k++) tick();
        chk("t5_id1", log_id[1], 1);
        chk("t5_id2", log_id[2], 1);
        chk("t5_id3", log_id[3], 2);
        chk("t5_data3", log_data[3], 8'h62);
`endif
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
